// File: rtl/partial_product_accumulator.sv
// Sequential accumulator for the five partial products of a 5x5 multiplier: one add per clock.
// Optional build macro PP_ACC_OVF_EN adds a sticky carry-out flag port named overflow.
module partial_product_accumulator #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] p1,
   input  logic [WIDTH-1:0] p2,
   input  logic [WIDTH-1:0] p3,
   input  logic [WIDTH-1:0] p4,
   input  logic [WIDTH-1:0] p5,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] product
`ifdef PP_ACC_OVF_EN
   ,
   output logic             overflow
`endif
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // valid is held by the source until that edge, and ready depends only on the FSM state.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [2:0]       cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] pp [5];
   logic [WIDTH-1:0] pp_sel;

   always_comb begin
      pp_sel = '0;
      case (cnt)
         3'd0:    pp_sel = pp[0];
         3'd1:    pp_sel = pp[1];
         3'd2:    pp_sel = pp[2];
         3'd3:    pp_sel = pp[3];
         3'd4:    pp_sel = pp[4];
         default: pp_sel = '0;
      endcase
   end

`ifdef PP_ACC_OVF_EN
   logic [WIDTH:0] sum;
   assign sum = {1'b0, acc} + {1'b0, pp_sel};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         acc   <= '0;
         for (int i = 0; i < 5; i++) pp[i] <= '0;
`ifdef PP_ACC_OVF_EN
         overflow <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  pp[0] <= p1;
                  pp[1] <= p2;
                  pp[2] <= p3;
                  pp[3] <= p4;
                  pp[4] <= p5;
                  acc   <= '0;
                  cnt   <= '0;
`ifdef PP_ACC_OVF_EN
                  overflow <= 1'b0;
`endif
                  state <= ACC;
               end
            end
            ACC: begin
`ifdef PP_ACC_OVF_EN
               acc      <= sum[WIDTH-1:0];
               overflow <= overflow | sum[WIDTH];
`else
               acc <= acc + pp_sel;
`endif
               cnt <= cnt + 3'd1;
               if (cnt == 3'd4) state <= DONE;
            end
            DONE: begin
               // Returning to IDLE never accepts in the same cycle; the next accept is a cycle later.
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign product   = acc;

endmodule

// File: tb/tb_partial_product_accumulator.sv
// Directed bench for partial_product_accumulator; build with +define+PP_ACC_OVF_EN to cover overflow.
module tb_partial_product_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [8:0] p1, p2, p3, p4, p5;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] product;
`ifdef PP_ACC_OVF_EN
   logic       overflow;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   partial_product_accumulator #(.WIDTH(9)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .p1        (p1),
      .p2        (p2),
      .p3        (p3),
      .p4        (p4),
      .p5        (p5),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
`ifdef PP_ACC_OVF_EN
      ,
      .overflow  (overflow)
`endif
   );

   // Driver: present a set at the current negedge, it is accepted on the next rising edge.
   task automatic start_op(input logic [8:0] a, b, c, d, e);
      p1 = a; p2 = b; p3 = c; p4 = d; p5 = e;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Driver: count negedges until out_valid, bounded at 20.
   task automatic wait_done(output int n);
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (out_valid) break;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      p1 = '0; p2 = '0; p3 = '0; p4 = '0; p5 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 9'd0) begin
         tests_failed++;
         $display("FAIL reset: in_ready=%b out_valid=%b product=%0d, want 1 0 0", in_ready, out_valid, product);
      end
`ifdef PP_ACC_OVF_EN
      tests_run++;
      if (overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_overflow: got %b want 0", overflow);
      end
`endif
   endtask

   task automatic test_basic();
      int n;
      out_ready = 1'b1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_ready_before: in_ready=%b want 1", in_ready);
      end
      start_op(9'd1, 9'd2, 9'd4, 9'd8, 9'd16);
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_busy: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
      end
      wait_done(n);
      tests_run++;
      if (n !== 5 || out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_latency: cycles=%0d out_valid=%b want 5 1", n, out_valid);
      end
      tests_run++;
      if (product !== 9'd31 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_product: product=%0d in_ready=%b want 31 0", product, in_ready);
      end
`ifdef PP_ACC_OVF_EN
      tests_run++;
      if (overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_overflow: got %b want 0", overflow);
      end
`endif
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 9'd31) begin
         tests_failed++;
         $display("FAIL basic_idle_hold: in_ready=%b out_valid=%b product=%0d want 1 0 31", in_ready, out_valid, product);
      end
   endtask

   task automatic test_wrap();
      int n;
      out_ready = 1'b1;
      start_op(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);
      wait_done(n);
      tests_run++;
      if (out_valid !== 1'b1 || product !== 9'h1FB) begin
         tests_failed++;
         $display("FAIL wrap_product: out_valid=%b product=%h want 1 1fb", out_valid, product);
      end
`ifdef PP_ACC_OVF_EN
      tests_run++;
      if (overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL wrap_overflow: got %b want 1", overflow);
      end
`endif
      @(negedge clk);
   endtask

   task automatic test_hold();
      int n;
      int bad = 0;
      out_ready = 1'b0;
      start_op(9'd3, 9'd5, 9'd7, 9'd9, 9'd11);
      wait_done(n);
      for (int i = 0; i < 3; i++) begin
         if (out_valid !== 1'b1 || product !== 9'd35 || in_ready !== 1'b0) bad++;
         in_valid = 1'b1;
         p1 = 9'($urandom_range(0, 511)); p2 = 9'($urandom_range(0, 511));
         p3 = 9'($urandom_range(0, 511)); p4 = 9'($urandom_range(0, 511));
         p5 = 9'($urandom_range(0, 511));
         @(negedge clk);
      end
      tests_run++;
      if (bad !== 0 || out_valid !== 1'b1 || product !== 9'd35) begin
         tests_failed++;
         $display("FAIL hold_done: bad_cycles=%0d out_valid=%b product=%0d want 0 1 35", bad, out_valid, product);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 9'd35) begin
         tests_failed++;
         $display("FAIL hold_release: in_ready=%b out_valid=%b product=%0d want 1 0 35", in_ready, out_valid, product);
      end
   endtask

   task automatic test_reset_midop();
      int seen = 0;
      out_ready = 1'b1;
      start_op(9'd10, 9'd20, 9'd30, 9'd40, 9'd50);
      repeat (2) @(negedge clk);
      tests_run++;
      if (product !== 9'd30 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL midop_partial: product=%0d in_ready=%b want 30 0", product, in_ready);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 9'd0) begin
         tests_failed++;
         $display("FAIL midop_async_reset: in_ready=%b out_valid=%b product=%0d want 1 0 0", in_ready, out_valid, product);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
      end
      tests_run++;
      if (seen !== 0) begin
         tests_failed++;
         $display("FAIL midop_no_stale: bad_cycles=%0d want 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      int acc_cyc [2];
      logic [8:0] prods [2];
      int n_acc = 0;
      int n_prod = 0;
      int both = 0;
      p1 = 9'd1; p2 = 9'd1; p3 = 9'd1; p4 = 9'd1; p5 = 9'd1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 40 && n_prod < 2; c++) begin
         if (in_ready && out_valid) both++;
         if (out_valid && n_prod < 2) begin
            prods[n_prod] = product;
            n_prod++;
         end
         if (in_ready && n_acc < 2) begin
            acc_cyc[n_acc] = c;
            n_acc++;
         end
         @(negedge clk);
         if (n_acc == 1) begin
            p1 = 9'd0; p2 = 9'd0; p3 = 9'd0; p4 = 9'd0; p5 = 9'h100;
         end
      end
      in_valid = 1'b0;
      tests_run++;
      if (n_prod !== 2 || n_acc !== 2) begin
         tests_failed++;
         $display("FAIL b2b_counts: products=%0d accepts=%0d want 2 2", n_prod, n_acc);
      end else begin
         tests_run++;
         if (prods[0] !== 9'd5 || prods[1] !== 9'h100) begin
            tests_failed++;
            $display("FAIL b2b_products: got %h %h want 005 100", prods[0], prods[1]);
         end
         tests_run++;
         if (acc_cyc[1] - acc_cyc[0] !== 7) begin
            tests_failed++;
            $display("FAIL b2b_spacing: got %0d want 7", acc_cyc[1] - acc_cyc[0]);
         end
      end
      tests_run++;
      if (both !== 0) begin
         tests_failed++;
         $display("FAIL b2b_exclusive: cycles with in_ready&out_valid=%0d want 0", both);
      end
`ifdef PP_ACC_OVF_EN
      tests_run++;
      if (overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_overflow: got %b want 0", overflow);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_hold();
      test_reset_midop();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
